// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: loads a program into instruction memory,
// then fetches sequentially with stall, redirect and halt handling.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   load_valid/data/last, load_ready  program loader handshake
//   reload                          leave HALT/FAULT back to LOAD
//   halt_req, stall                 decode-side fetch control
//   redirect_valid, redirect_pc     taken branch/jump (word address)
//   mem_addr, mem_we, mem_wdata     instruction memory port (combinational)
//   mem_rdata                       combinational memory read data
//   instr, instr_pc, instr_valid    fetched instruction (registered)
//   halted, fault                   state flags (registered)
module fetch_ctrl #(
  parameter int unsigned MEM_DEPTH = 32,
  parameter logic [31:0] RESET_PC  = 32'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        load_ready,
  input  logic        reload,
  input  logic        halt_req,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic        halted,
  output logic        fault
);

  localparam int unsigned CNT_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_DEPTH - 1);
  localparam logic [31:0] DEPTH_W = 32'(MEM_DEPTH);

  typedef enum logic [1:0] {LOAD, RUN, HALT, FAULT} state_t;

  state_t           state, state_d;
  logic [31:0]      pc, pc_d;
  logic [CNT_W-1:0] load_cnt, load_cnt_d;
  logic [31:0]      instr_d, instr_pc_d;
  logic             instr_valid_d;
  logic             load_fire;

  // Memory port and loader handshake; reset gates load_ready so nothing is
  // written before the first edge after rst_n rises.
  always_comb begin
    load_ready = rst_n && (state == LOAD);
    load_fire  = load_ready && load_valid;
    mem_we     = load_fire;
    mem_wdata  = load_data;
    mem_addr   = (state == LOAD) ? 32'(load_cnt) : pc;
  end

  // Next-state and fetch pipeline update
  always_comb begin
    state_d       = state;
    pc_d          = pc;
    load_cnt_d    = load_cnt;
    instr_d       = instr;
    instr_pc_d    = instr_pc;
    instr_valid_d = 1'b0;
    case (state)
      LOAD: begin
        if (load_fire) begin
          if (load_last || (load_cnt == LAST_CNT)) begin
            state_d    = RUN;
            pc_d       = RESET_PC;
            load_cnt_d = '0;
          end else begin
            load_cnt_d = load_cnt + CNT_W'(1);
          end
        end
      end
      RUN: begin
        if (redirect_valid) begin
          // Squash the wrong-path fetch; an out-of-range target faults next cycle
          pc_d = redirect_pc;
        end else if (pc >= DEPTH_W) begin
          state_d = FAULT;
        end else if (halt_req) begin
          state_d = HALT;
        end else if (stall) begin
          instr_valid_d = instr_valid;
        end else begin
          instr_d       = mem_rdata;
          instr_pc_d    = pc;
          instr_valid_d = 1'b1;
          pc_d          = pc + 32'd1;
        end
      end
      HALT, FAULT: begin
        if (reload) begin
          state_d    = LOAD;
          load_cnt_d = '0;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= LOAD;
      pc          <= RESET_PC;
      load_cnt    <= '0;
      instr       <= 32'd0;
      instr_pc    <= 32'd0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_d;
      pc          <= pc_d;
      load_cnt    <= load_cnt_d;
      instr       <= instr_d;
      instr_pc    <= instr_pc_d;
      instr_valid <= instr_valid_d;
      halted      <= (state_d == HALT);
      fault       <= (state_d == FAULT);
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  localparam int unsigned DEPTH = 32;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  logic        clk, rst_n;
  logic        load_valid, load_last, load_ready;
  logic [31:0] load_data;
  logic        reload, halt_req, stall, redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
  logic [31:0] instr, instr_pc;
  logic        instr_valid, halted, fault;

  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  exp_t        exp_q[$];
  int          total = 0;
  int          bad   = 0;

  fetch_ctrl #(.MEM_DEPTH(DEPTH), .RESET_PC(32'd0)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .reload(reload), .halt_req(halt_req),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .halted(halted), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model
  assign mem_rdata = (mem_addr < DEPTH) ? mem[mem_addr[4:0]] : 32'hDEAD_BEEF;
  always @(posedge clk) if (mem_we && (mem_addr < DEPTH)) mem[mem_addr[4:0]] <= mem_wdata;

  // Scoreboard consumer: every valid instruction must match the next expectation
  always @(posedge clk) begin
    #1;
    if (rst_n && instr_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected got pc=%0d instr=%h want no valid instr", instr_pc, instr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (instr_pc !== e.pc || instr !== e.ins) begin
          bad++;
          $display("FAIL sb_instr got pc=%0d instr=%h want pc=%0d instr=%h", instr_pc, instr, e.pc, e.ins);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int a);
    exp_q.push_back('{pc: 32'(a), ins: ref_mem[a]});
  endtask

  task automatic test_reset;
    #3;
    total++;
    if ({load_ready, mem_we, halted, fault, instr_valid} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags got %b want 00000", {load_ready, mem_we, halted, fault, instr_valid});
    end
    total++;
    if (instr !== 32'd0 || instr_pc !== 32'd0) begin
      bad++;
      $display("FAIL reset_instr got %h/%h want 0/0", instr_pc, instr);
    end
    tick();
    rst_n = 1'b1;
    load_valid = 1'b0;
  endtask

  task automatic test_load_run;
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1;
      load_data  = 32'(32'h11 * (i + 1));
      load_last  = (i == 3);
      ref_mem[i] = load_data;
      #1;
      total++;
      if (mem_we !== 1'b1 || mem_addr !== 32'(i)) begin
        bad++;
        $display("FAIL load_write got we=%b addr=%0d want we=1 addr=%0d", mem_we, mem_addr, i);
      end
      tick();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    load_data  = 32'hCAFE_F00D;
    #1;
    total++;
    if (load_ready !== 1'b0 || mem_addr !== 32'd0 || mem_wdata !== 32'hCAFE_F00D) begin
      bad++;
      $display("FAIL run_entry got rdy=%b addr=%0d wdata=%h want 0/0/cafef00d", load_ready, mem_addr, mem_wdata);
    end
    push(0); push(1); push(2);
    repeat (3) tick();
  endtask

  task automatic test_redirect;
    push(3); tick();
    push(4); tick();
    total++;
    if (mem_addr !== 32'd5) begin
      bad++;
      $display("FAIL redir_pc got %0d want 5", mem_addr);
    end
    redirect_valid = 1'b1; redirect_pc = 32'd2; stall = 1'b1;
    tick();
    redirect_valid = 1'b0; stall = 1'b0;
    #1;
    total++;
    if (instr_valid !== 1'b0 || mem_addr !== 32'd2) begin
      bad++;
      $display("FAIL redir_bubble got valid=%b addr=%0d want 0/2", instr_valid, mem_addr);
    end
    push(2); tick();
    total++;
    if (instr_valid !== 1'b1) begin
      bad++;
      $display("FAIL redir_target got valid=%b want 1", instr_valid);
    end
  endtask

  task automatic test_stall;
    push(3); tick();
    stall = 1'b1;
    push(3); push(3); push(3);
    repeat (3) tick();
    stall = 1'b0;
    push(4); tick();
  endtask

  task automatic test_halt;
    halt_req = 1'b1; load_valid = 1'b1; load_data = 32'h77;
    tick();
    halt_req = 1'b0;
    #1;
    total++;
    if ({halted, fault, instr_valid, load_ready, mem_we} !== 5'b10000 || mem_addr !== 32'd5) begin
      bad++;
      $display("FAIL halt_state got h/f/v/r/we=%b addr=%0d want 10000 addr=5", {halted, fault, instr_valid, load_ready, mem_we}, mem_addr);
    end
    tick();
    total++;
    if (halted !== 1'b1) begin
      bad++;
      $display("FAIL halt_sticky got %b want 1", halted);
    end
    load_valid = 1'b0;
    reload = 1'b1;
    tick();
    reload = 1'b0;
    #1;
    total++;
    if (halted !== 1'b0 || load_ready !== 1'b1 || mem_addr !== 32'd0) begin
      bad++;
      $display("FAIL halt_reload got h=%b rdy=%b addr=%0d want 0/1/0", halted, load_ready, mem_addr);
    end
  endtask

  task automatic test_reset_midrun;
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1;
      load_data  = 32'hB0 + 32'(i);
      load_last  = (i == 2);
      ref_mem[i] = load_data;
      tick();
    end
    load_last = 1'b0;
    push(0); push(1);
    tick(); tick();
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({instr_valid, halted, fault, load_ready, mem_we} !== 5'b0 || instr !== 32'd0 || instr_pc !== 32'd0) begin
      bad++;
      $display("FAIL async_reset got v/h/f/r/we=%b instr=%h pc=%0d want 00000/0/0", {instr_valid, halted, fault, load_ready, mem_we}, instr, instr_pc);
    end
    tick();
    rst_n = 1'b1;
    load_data = 32'hC0; load_last = 1'b1; ref_mem[0] = 32'hC0;
    tick();
    load_valid = 1'b0; load_last = 1'b0;
    push(0); push(1); push(2);
    repeat (3) tick();
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    reload = 1'b1; tick(); reload = 1'b0;
  endtask

  task automatic test_autoload_fault;
    for (int i = 0; i < 32; i++) begin
      load_valid = 1'b1;
      load_data  = 32'h1000 + 32'(i);
      ref_mem[i] = load_data;
      if (i == 31) begin
        #1;
        total++;
        if (mem_addr !== 32'd31 || mem_we !== 1'b1) begin
          bad++;
          $display("FAIL auto_last got addr=%0d we=%b want 31/1", mem_addr, mem_we);
        end
      end
      tick();
    end
    load_valid = 1'b0;
    for (int i = 0; i < 32; i++) push(i);
    repeat (32) tick();
    total++;
    if (mem_addr !== 32'd32 || fault !== 1'b0) begin
      bad++;
      $display("FAIL auto_end got addr=%0d fault=%b want 32/0", mem_addr, fault);
    end
    tick();
    total++;
    if (fault !== 1'b1 || instr_valid !== 1'b0 || halted !== 1'b0) begin
      bad++;
      $display("FAIL oor_fault got f=%b v=%b h=%b want 1/0/0", fault, instr_valid, halted);
    end
    tick();
    total++;
    if (fault !== 1'b1) begin
      bad++;
      $display("FAIL fault_sticky got %b want 1", fault);
    end
    reload = 1'b1; tick(); reload = 1'b0;
    #1;
    total++;
    if (fault !== 1'b0 || load_ready !== 1'b1) begin
      bad++;
      $display("FAIL fault_reload got f=%b rdy=%b want 0/1", fault, load_ready);
    end
  endtask

  task automatic test_redirect_oor;
    load_valid = 1'b1; load_data = 32'hD0; load_last = 1'b1; ref_mem[0] = 32'hD0;
    tick();
    load_valid = 1'b0; load_last = 1'b0;
    reload = 1'b1;
    push(0); tick();
    reload = 1'b0;
    total++;
    if (load_ready !== 1'b0 || halted !== 1'b0 || fault !== 1'b0) begin
      bad++;
      $display("FAIL reload_in_run got rdy=%b h=%b f=%b want 0/0/0", load_ready, halted, fault);
    end
    redirect_valid = 1'b1; redirect_pc = 32'd40;
    tick();
    redirect_valid = 1'b0;
    #1;
    total++;
    if (instr_valid !== 1'b0 || fault !== 1'b0 || mem_addr !== 32'd40) begin
      bad++;
      $display("FAIL redir_oor got v=%b f=%b addr=%0d want 0/0/40", instr_valid, fault, mem_addr);
    end
    tick();
    total++;
    if (fault !== 1'b1 || instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL redir_oor_fault got f=%b v=%b want 1/0", fault, instr_valid);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i]     = 32'hA000_0000 | 32'(i);
      ref_mem[i] = 32'hA000_0000 | 32'(i);
    end
    rst_n = 1'b0; load_valid = 1'b1; load_data = 32'h0; load_last = 1'b0;
    reload = 1'b0; halt_req = 1'b0; stall = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'd0;
    test_reset();
    test_load_run();
    test_redirect();
    test_stall();
    test_halt();
    test_reset_midrun();
    test_autoload_fault();
    test_redirect_oor();
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 32, meaning number of 32-bit instruction words; word-indexed addresses 0..MEM_DEPTH-1.
REQ-002 SHALL have parameter RESET_PC, default 0, meaning first fetch address after a load completes.
REQ-003 SHALL have ports, one per line:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load_valid  in  1  loader presents a word.
- load_data  in  32  word to write.
- load_last  in  1  qualifies the final word of the program.
- load_ready  out  1  controller accepts a loader word this cycle.
- reload  in  1  request to return from HALT/FAULT to LOAD.
- halt_req  in  1  stop fetching (from decode).
- stall  in  1  hold the fetch stage.
- redirect_valid  in  1  branch/jump taken.
- redirect_pc  in  32  branch/jump target, word address.
- mem_addr  out  32  instruction memory address, read and write.
- mem_we  out  1  instruction memory write enable.
- mem_wdata  out  32  instruction memory write data.
- mem_rdata  in  32  combinational read data from instruction memory.
- instr  out  32  fetched instruction.
- instr_pc  out  32  address of instr.
- instr_valid  out  1  instr/instr_pc valid.
- halted  out  1  state is HALT.
- fault  out  1  state is FAULT.

Function
REQ-004 SHALL implement FSM states LOAD, RUN, HALT, FAULT; the reset state SHALL be LOAD.
REQ-005 In LOAD: load_ready=1. A write SHALL occur on load_valid&&load_ready: mem_we=1, mem_addr=load_cnt, mem_wdata=load_data. load_cnt SHALL then increment by 1.
REQ-006 In LOAD, an accepted word with load_last=1, or an accepted word at load_cnt=MEM_DEPTH-1, SHALL move to RUN next cycle. It SHALL also set pc=RESET_PC and clear load_cnt.
REQ-007 Outside LOAD: load_ready=0, mem_we=0, and load_valid SHALL be ignored. mem_wdata SHALL follow load_data in every state; only mem_we qualifies it.
REQ-008 In RUN: mem_addr=pc combinationally, with mem_we=0.
REQ-009 Each RUN cycle SHALL resolve by priority redirect > halt_req > stall > normal:
- normal: instr<=mem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+1 (word increment, 32-bit wrap).
- stall: pc, instr, instr_pc, instr_valid held.
- halt_req: instr_valid<=0, go to HALT, pc held.
- redirect: pc<=redirect_pc, instr_valid<=0 (squash wrong-path fetch), ignoring stall and halt_req that cycle.
REQ-010 Fetch latency SHALL be one cycle: an address presented in cycle t SHALL appear on instr with instr_valid=1 after edge t+1.
REQ-011 A redirect SHALL cost exactly one bubble: the target instruction SHALL be valid two edges after redirect_valid.
REQ-012 In RUN with no redirect, pc>=MEM_DEPTH SHALL cause FAULT next cycle with instr_valid<=0; no out-of-range word is presented as valid.
REQ-013 A redirect_pc>=MEM_DEPTH SHALL be accepted into pc and SHALL fault on the following cycle per REQ-012.
REQ-014 In HALT and FAULT: instr_valid=0, mem_addr=pc, pc held. halted=1 in HALT only; fault=1 in FAULT only. Both states are sticky until reload.
REQ-015 reload=1 in HALT or FAULT SHALL go to LOAD next cycle with load_cnt=0. reload SHALL be ignored in LOAD and RUN.
REQ-016 Outputs SHALL be registered except mem_addr, mem_we, mem_wdata and load_ready, which SHALL be combinational from state, counters and load inputs.

Reset
REQ-017 rst_n=0 SHALL asynchronously force: state=LOAD, pc=RESET_PC, load_cnt=0, instr=0, instr_pc=0, instr_valid=0.
REQ-018 Under reset, halted=0, fault=0, mem_we=0 and load_ready=0.
REQ-019 Reset asserted mid-load or mid-run SHALL abort the operation; memory contents already written are left intact.
REQ-020 After rst_n deasserts, the first write SHALL be accepted no earlier than the first rising edge after deassertion.

Verification
REQ-021 Load 4 words 0x11,0x22,0x33,0x44 with load_last on the 4th -> writes at addresses 0..3, RUN entered. Then instr_pc/instr = 0/0x11, 1/0x22, 2/0x33 on consecutive cycles.
REQ-022 In RUN at pc=5, redirect_valid with redirect_pc=2 and stall=1 in the same cycle -> instr_valid=0 for one cycle, then instr_pc=2 valid; the stall is ignored.
REQ-023 stall held 3 cycles at instr_pc=3 -> instr, instr_pc and instr_valid unchanged for 3 cycles; afterwards instr_pc=4 next.
REQ-024 Load 32 words without load_last -> automatic RUN after address 31. Execute to pc=32 -> fault=1, instr_valid=0. Then reload -> LOAD, load_ready=1.
REQ-025 halt_req in RUN -> halted=1, instr_valid=0, load_valid ignored. rst_n pulse mid-run -> all outputs at REQ-017/REQ-018 values immediately, without a clock edge.
